// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame controller and its sync detector.
package serial_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SHIFT,
        PARITY,
        DONE
    } frame_state_t;

    localparam int DATA_BITS = 8;

    localparam int         SYNC_LEN_DEFAULT     = 4;
    localparam logic [3:0] SYNC_PATTERN_DEFAULT = 4'b1101;

endpackage

// File: rtl/sync_detector.sv
// Sync-pattern hunter: history of the serial line, fill counter that blocks matches on
// reset/cleared zeros, and the combinational match against the sync pattern.
module sync_detector
    import serial_pkg::*;
#(
    parameter int                  SYNC_LEN     = SYNC_LEN_DEFAULT,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic serIn,
    input  logic hunt_en,
    input  logic clr,
    output logic match
);

    localparam int FILL_W = $clog2(SYNC_LEN + 1);

    if (SYNC_LEN < 2 || SYNC_LEN > DATA_BITS) begin : g_bad_len
        $error("sync_detector: SYNC_LEN must be in 2..8");
    end

    // Only the newest SYNC_LEN-1 bits are stored; the live serIn completes the window.
    logic [SYNC_LEN-2:0] hist_q;
    logic [SYNC_LEN-2:0] hist_d;
    logic [SYNC_LEN-1:0] window;
    logic [FILL_W-1:0]   fill_q;

    assign window = {hist_q, serIn};
    assign hist_d = window[SYNC_LEN-2:0];
    assign match  = hunt_en && (fill_q >= FILL_W'(SYNC_LEN - 1)) && (window == SYNC_PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (hunt_en) begin
            hist_q <= hist_d;
            if (fill_q != FILL_W'(SYNC_LEN))
                fill_q <= fill_q + FILL_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Frame control FSM driving the 3-bit counter / 8-bit shift register downstream.
// Optional even-parity bit after the data byte: define SERIAL_FRAME_PARITY_EN.
module serial_frame_ctrl
    import serial_pkg::*;
#(
    parameter int                  SYNC_LEN     = SYNC_LEN_DEFAULT,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serIn,
    input  logic       co,
    output logic       iz0,
    output logic       cen,
    output logic       shen,
    output logic       busy,
    output logic       frame_valid,
`ifdef SERIAL_FRAME_PARITY_EN
    output logic       parity_err,
`endif
    output logic [7:0] frame_cnt
);

    frame_state_t state_q;
    logic         cen_q;
    logic         shen_q;
    logic         busy_q;
    logic         frame_valid_q;
    logic [7:0]   frame_cnt_q;
    logic         match;
    logic         hunt_en;
    logic         hist_clr;
`ifdef SERIAL_FRAME_PARITY_EN
    logic         par_q;
    logic         parity_err_q;
`endif

    assign hunt_en  = (state_q == HUNT);
    assign hist_clr = (state_q == DONE);

    sync_detector #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .serIn   (serIn),
        .hunt_en (hunt_en),
        .clr     (hist_clr),
        .match   (match)
    );

    // Mealy clear: counter and shift register are zeroed on the edge that enters SHIFT.
    assign iz0         = match;
    assign cen         = cen_q;
    assign shen        = shen_q;
    assign busy        = busy_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef SERIAL_FRAME_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

    // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= HUNT;
            cen_q         <= 1'b0;
            shen_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
            case (state_q)
                HUNT: begin
                    if (match) begin
                        state_q <= SHIFT;
                        cen_q   <= 1'b1;
                        shen_q  <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
                        par_q   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
`ifdef SERIAL_FRAME_PARITY_EN
                    par_q <= par_q ^ serIn;
`endif
                    // co marks the eighth data bit; the counter wraps to 0 on this edge.
                    if (co) begin
                        cen_q  <= 1'b0;
                        shen_q <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q       <= DONE;
                        busy_q        <= 1'b0;
                        frame_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                PARITY: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    if (par_q ^ serIn)
                        parity_err_q  <= 1'b1;
                    else
                        frame_valid_q <= 1'b1;
                end
`endif
                DONE: begin
                    // Guard bit: serIn is ignored while the sync history is cleared.
                    state_q <= HUNT;
                    if (frame_valid_q)
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                end
                default: state_q <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl with a behavioural counter/shift-register downstream
// and a bit-stream reference model that parses frames directly from the transmitted bits.
module tb_serial_frame_ctrl;
    import serial_pkg::*;

    localparam int         SYNC_LEN     = SYNC_LEN_DEFAULT;
    localparam logic [3:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] cnt;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ser_in = 1'b0;
    logic       co;
    logic       iz0, cen, shen, busy, frame_valid;
    logic [7:0] frame_cnt;
`ifdef SERIAL_FRAME_PARITY_EN
    logic       parity_err;
`endif

    serial_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .serIn       (ser_in),
        .co          (co),
        .iz0         (iz0),
        .cen         (cen),
        .shen        (shen),
        .busy        (busy),
        .frame_valid (frame_valid),
`ifdef SERIAL_FRAME_PARITY_EN
        .parity_err  (parity_err),
`endif
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // Downstream 3-bit counter and LSB-first serial-to-parallel register.
    logic [2:0] cnt_m;
    logic [7:0] par_out;
    assign co = (cnt_m == 3'd7);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_m   <= 3'd0;
            par_out <= 8'd0;
        end else if (iz0) begin
            cnt_m   <= 3'd0;
            par_out <= 8'd0;
        end else begin
            if (cen)  cnt_m   <= cnt_m + 3'd1;
            if (shen) par_out <= {ser_in, par_out[7:1]};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard state produced by the reference model.
    bit     seg[$];
    bit     win[$];
    int     iz0_q[$];
    int     perr_q[$];
    frame_t fq[$];
    bit     busy_exp[int];
    bit     shen_exp[int];
    int     nvalid = 0;
    int     cyc = -1;
    bit     mon_en = 1'b0;
    logic [7:0] last_byte = 8'd0;

    function automatic bit win_is_sync();
        if (win.size() != SYNC_LEN) return 1'b0;
        for (int k = 0; k < SYNC_LEN; k++)
            if (win[k] != SYNC_PATTERN[SYNC_LEN-1-k]) return 1'b0;
        return 1'b1;
    endfunction

    // Parse the segment as the protocol defines it: hunt on the last SYNC_LEN bits, then
    // take eight data bits (plus parity), skip the guard bit and hunt again from scratch.
    task automatic model_segment(input int base);
        int         i;
        int         n;
        int         s;
        logic [7:0] d;
        bit         ok;
        i = 0;
        n = seg.size();
        while (i < n) begin
            win.push_back(seg[i]);
            if (win.size() > SYNC_LEN) void'(win.pop_front());
            if (win_is_sync()) begin
                s = base + i;
                iz0_q.push_back(s);
                for (int k = 1; k <= DATA_BITS + PB; k++) begin
                    busy_exp[s+k] = 1'b1;
                    if (k <= DATA_BITS) shen_exp[s+k] = 1'b1;
                end
                if (i + DATA_BITS + PB < n) begin
                    for (int k = 0; k < DATA_BITS; k++) d[k] = seg[i+1+k];
                    ok = 1'b1;
                    if (PB == 1) ok = ((^d) == seg[i+1+DATA_BITS]);
                    if (ok) begin
                        nvalid++;
                        fq.push_back('{s + DATA_BITS + PB + 1, d, 8'(nvalid)});
                    end else begin
                        perr_q.push_back(s + DATA_BITS + PB + 1);
                    end
                end
                win.delete();
                i += DATA_BITS + PB + 2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic add_sync();
        for (int k = SYNC_LEN - 1; k >= 0; k--) seg.push_back(SYNC_PATTERN[k]);
    endtask

    task automatic add_data(input logic [7:0] d, input bit par_ok, input bit guard);
        for (int k = 0; k < DATA_BITS; k++) seg.push_back(d[k]);
        if (PB == 1) seg.push_back(par_ok ? (^d) : ~(^d));
        seg.push_back(guard);
    endtask

    task automatic drive_seg();
        model_segment(cyc + 1);
        foreach (seg[k]) begin
            @(posedge clk);
            #1;
            ser_in = seg[k];
            cyc++;
        end
        seg.delete();
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ser_in = 1'($urandom);
            @(negedge clk);
            check("reset_outputs", 32'({iz0, cen, shen, busy, frame_valid}), 32'd0);
            check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        end
    endtask

    task automatic release_reset();
        check("abort_no_frame_pending", 32'(fq.size()), 32'd0);
        win.delete();
        busy_exp.delete();
        shen_exp.delete();
        iz0_q.delete();
        nvalid = 0;
        @(posedge clk);
        #1;
        ser_in = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compares every cycle against the scoreboard, popping on DUT events.
    bit         e_iz0, e_fv, cnt_pend;
    logic [7:0] pend_cnt;
    always @(negedge clk) begin
        if (mon_en) begin
            e_iz0 = (iz0_q.size() > 0) && (iz0_q[0] == cyc);
            check("iz0", 32'(iz0), 32'(e_iz0));
            if (e_iz0) void'(iz0_q.pop_front());
            check("busy", 32'(busy), 32'(busy_exp.exists(cyc)));
            check("shen", 32'(shen), 32'(shen_exp.exists(cyc)));
            check("cen", 32'(cen), 32'(shen_exp.exists(cyc)));
            if (cnt_pend) begin
                check("frame_cnt", 32'(frame_cnt), 32'(pend_cnt));
                cnt_pend = 1'b0;
            end
            e_fv = (fq.size() > 0) && (fq[0].idx == cyc);
            check("frame_valid", 32'(frame_valid), 32'(e_fv));
            if (e_fv) begin
                check("parOut", 32'(par_out), 32'(fq[0].data));
                last_byte = par_out;
                pend_cnt  = fq[0].cnt;
                cnt_pend  = 1'b1;
                void'(fq.pop_front());
            end
`ifdef SERIAL_FRAME_PARITY_EN
            begin
                bit e_pe;
                e_pe = (perr_q.size() > 0) && (perr_q[0] == cyc);
                check("parity_err", 32'(parity_err), 32'(e_pe));
                if (e_pe) void'(perr_q.pop_front());
            end
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle;

        // Reset held with a toggling line: everything stays quiet.
        hold_reset(6);
        release_reset();

        // Zeros only: no sync, no iz0.
        repeat (4) seg.push_back(1'b0);
        drive_seg();

        // Abort after four data bits: busy drops at once, no frame is reported.
        add_sync();
        seg.push_back(1'b1); seg.push_back(1'b0); seg.push_back(1'b1); seg.push_back(1'b1);
        drive_seg();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_outputs", 32'({iz0, cen, shen, frame_valid}), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        hold_reset(3);
        release_reset();

        // Single frame 10110010 (LSB first) -> 0x4D.
        add_sync();
        add_data(8'h4D, 1'b1, 1'b0);
        seg.push_back(1'b0); seg.push_back(1'b0);
        drive_seg();
        check("single_byte", 32'(last_byte), 32'h4D);
        check("single_cnt", 32'(frame_cnt), 32'd1);

        // Sync pattern embedded in data is ignored, then a fresh frame after the guard bit.
        add_sync();
        add_data(8'hBB, 1'b1, 1'b1);
        add_sync();
        add_data(8'h0D, 1'b1, 1'b0);
        seg.push_back(1'b0); seg.push_back(1'b0);
        drive_seg();
        check("embedded_cnt", 32'(frame_cnt), 32'd3);

`ifdef SERIAL_FRAME_PARITY_EN
        // Same byte with a wrong parity bit: parity_err, no frame_valid, count unchanged.
        add_sync();
        add_data(8'h4D, 1'b0, 1'b0);
        seg.push_back(1'b0); seg.push_back(1'b0);
        drive_seg();
        check("bad_parity_cnt", 32'(frame_cnt), 32'd3);
`endif

        // Randomised traffic with random idle gaps; long enough to wrap frame_cnt.
        for (int f = 0; f < 380; f++) begin
            idle = $urandom_range(0, 4);
            repeat (idle) seg.push_back(1'($urandom));
            add_sync();
            add_data(8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
        end
        repeat (10) seg.push_back(1'b0);
        drive_seg();
        @(negedge clk);
        @(negedge clk);

        check("final_frame_cnt", 32'(frame_cnt), 32'(nvalid % 256));
        check("pending_frames", 32'(fq.size()), 32'd0);
        check("pending_iz0", 32'(iz0_q.size()), 32'd0);
        check("pending_parity_err", 32'(perr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_ctrl.md
Name: serial_frame_ctrl

Overview:
Control FSM that sits directly upstream of the 3-bit counter / 8-bit serial-to-parallel shift register. It watches the raw serial line for a sync pattern. On a match it zeroes the counter and shift register, then enables eight data-bit shifts and signals completion using the counter's carry-out. It emits a one-cycle frame_valid pulse when parOut holds a complete byte, and keeps a running count of received frames.

Parameters:
SYNC_LEN, 4, number of bits in the sync pattern (legal range 2..8)
SYNC_PATTERN, 4'b1101, sync pattern; MSB is received first; width SYNC_LEN

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
serIn  input  1  raw serial line; sampled on every rising clk edge
co  input  1  counter carry-out; high when counter state == 7
iz0  output  1  synchronous clear to counter and shift register
cen  output  1  counter enable
shen  output  1  shift register enable
busy  output  1  high while in SHIFT (and PARITY when enabled)
frame_valid  output  1  one-cycle pulse; downstream parOut holds the completed byte
frame_cnt  output  8  number of valid frames since reset; wraps 255 -> 0

Behaviour:
- Reset (rst low, asynchronous): state=HUNT; sync history=0; fill count=0; frame_cnt=0.
- Reset state of outputs: iz0=cen=shen=busy=frame_valid=0.
- Reset mid-frame aborts the frame immediately. No frame_valid pulse is issued and frame_cnt does not change.
- History register hist[SYNC_LEN-1:0] shifts serIn in at its LSB every cycle, but only in HUNT.
- Fill counter saturates at SYNC_LEN. No match is possible until SYNC_LEN bits have been collected since reset or since DONE. This prevents false matches on reset zeros.
- match (combinational) = HUNT && fill >= SYNC_LEN-1 && {hist[SYNC_LEN-2:0], serIn} == SYNC_PATTERN.
- States:
  - HUNT: iz0 = match (Mealy output). On match, go to SHIFT next cycle. The counter and shift register are therefore zero when the first data bit arrives.
  - SHIFT: cen=shen=1 and busy=1. Data bits are taken LSB first by the downstream shift register.
  - SHIFT exit: when co=1, the current cycle is the 8th shift. Next state is DONE, or PARITY when the feature is enabled. The counter wraps to 0 on that cycle.
  - DONE: frame_valid=1 for exactly one cycle; frame_cnt increments. hist and fill are cleared. serIn is ignored (a one-bit guard interval is mandatory in the protocol). Next state is HUNT.
- Latency: last sync bit at edge N; data bits sampled at edges N+1..N+8; frame_valid high during cycle N+9.
- A sync pattern embedded in the data bits is not detected, because hunting is disabled outside HUNT.
- Overlapping sync patterns in HUNT (e.g. 1101101) match at the first completion only.
- co asserted in HUNT or DONE is ignored.

Optional Feature:
Macro: SERIAL_FRAME_PARITY_EN
- Defined:
  - An extra PARITY state follows SHIFT. The running XOR of the 8 data bits is accumulated in SHIFT.
  - In PARITY, serIn is the even-parity bit; cen=shen=0 and busy=1.
  - Extra output parity_err (1 bit, reset 0) pulses in the DONE cycle on a parity mismatch.
  - frame_valid and the frame_cnt increment occur only when parity is correct.
  - Latency grows by 1 cycle.
- Not defined: no PARITY state and no parity_err port; SHIFT goes directly to DONE.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum typedef frame_state_t (HUNT, SHIFT, PARITY, DONE);
  - localparam DATA_BITS=8;
  - default SYNC constants.
- One sub-module is natural: sync_detector. It contains the history register, the fill counter and the match comparator, with inputs clk, rst, serIn, hunt_en and clr, and output match.
- The FSM and frame counter stay in the top.

Test Plan:
- Reset check: hold rst=0, toggle serIn -> all outputs 0 and frame_cnt=0. Release rst and feed 0000 -> no iz0.
- Single frame: send 1101 followed by data 10110010 (LSB first) with a behavioural counter/shreg model attached -> iz0 in the cycle of the last sync bit, shen high 8 cycles, frame_valid in the following cycle, parOut=8'h4D, frame_cnt=1.
- Sync inside data: send 1101 then data 1101_1101 -> exactly one frame_valid, no iz0 during SHIFT; then a fresh 1101 after the guard bit -> second frame, frame_cnt=2.
- Reset mid-frame: drive rst low after 4 data bits -> busy=0 immediately, no frame_valid, frame_cnt unchanged; the next full frame is received correctly.
- Wrap: 256 back-to-back frames -> frame_cnt returns to 0.
- With SERIAL_FRAME_PARITY_EN: send data 8'h4D with parity 0 -> frame_valid, parity_err=0; then send the same data with parity 1 -> parity_err pulse, no frame_valid, frame_cnt unchanged.
